// File: rtl/instr_imm_encoder.sv
// Streaming instruction encoder: range-checks and packs immediates, buffers words in a small FIFO.
// Optional IMM_CLAMP_EN: clamp out-of-range immediates to the class limits and still push the word.
module instr_imm_encoder #(
  parameter int FIFO_DEPTH = 2,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_opcode,
  input  logic [3:0]           in_rd,
  input  logic [3:0]           in_rs,
  input  logic [3:0]           in_rt,
  input  logic [15:0]          in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          out_instr,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [15:0]          word_cnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [15:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic [15:0] enc_word;
  logic        range_err;
  logic [3:0]  imm4;
  logic [7:0]  imm8;
  logic [8:0]  imm9;
  logic        accept;
  logic        pop;
  logic        push;

  assign in_ready  = (count < CNT_W'(FIFO_DEPTH));
  assign out_valid = (count != '0);
  assign out_instr = mem[rd_ptr];
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Signed classes are in range when every bit above the field's sign bit matches it.
  always_comb begin
    range_err = 1'b0;
    imm4      = in_imm[3:0];
    imm8      = in_imm[7:0];
    imm9      = in_imm[8:0];
    enc_word  = {in_opcode, in_rd, in_rs, in_rt};
    case (in_opcode)
      4'b0100, 4'b0101, 4'b0110: begin
        range_err = |in_imm[15:4];
`ifdef IMM_CLAMP_EN
        if (range_err) imm4 = 4'hF;
`endif
        enc_word = {in_opcode, in_rd, in_rs, imm4};
      end
      4'b1000, 4'b1001: begin
        range_err = !((&in_imm[15:3]) || !(|in_imm[15:3]));
`ifdef IMM_CLAMP_EN
        if (range_err) imm4 = in_imm[15] ? 4'h8 : 4'h7;
`endif
        enc_word = {in_opcode, in_rd, in_rs, imm4};
      end
      4'b1010: begin
        range_err = !((&in_imm[15:7]) || !(|in_imm[15:7]));
`ifdef IMM_CLAMP_EN
        if (range_err) imm8 = in_imm[15] ? 8'h80 : 8'h7F;
`endif
        enc_word = {in_opcode, in_rd, imm8};
      end
      4'b1011: begin
        range_err = |in_imm[15:8];
`ifdef IMM_CLAMP_EN
        if (range_err) imm8 = 8'hFF;
`endif
        enc_word = {in_opcode, in_rd, imm8};
      end
      4'b1100, 4'b1101, 4'b1110: begin
        range_err = !((&in_imm[15:8]) || !(|in_imm[15:8]));
`ifdef IMM_CLAMP_EN
        if (range_err) imm9 = in_imm[15] ? 9'h100 : 9'h0FF;
`endif
        enc_word = {in_opcode, in_rd[2:0], imm9};
      end
      4'b1111: enc_word = {in_opcode, 12'h000};
      default: enc_word = {in_opcode, in_rd, in_rs, in_rt};
    endcase
  end

`ifdef IMM_CLAMP_EN
  assign push = accept;
`else
  assign push = accept & ~range_err;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= enc_word;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Error counter saturates rather than wrapping so a long run of bad input stays visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_pulse <= 1'b0;
      err_cnt   <= '0;
      word_cnt  <= '0;
    end else begin
      err_pulse <= accept & range_err;
      if (accept && range_err && (err_cnt != '1)) err_cnt <= err_cnt + ERR_CNT_W'(1);
      if (pop) word_cnt <= word_cnt + 16'(1);
    end
  end

endmodule

// File: tb/tb_instr_imm_encoder.sv
// Directed self-checking bench for instr_imm_encoder; expected words are hand-packed from the encoding table.
module tb_instr_imm_encoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode;
  logic [3:0]  in_rd;
  logic [3:0]  in_rs;
  logic [3:0]  in_rt;
  logic [15:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic        err_pulse;
  logic [7:0]  err_cnt;
  logic [15:0] word_cnt;

  int total = 0;
  int bad = 0;
  logic [15:0] exp_wc = 16'd0;

  instr_imm_encoder #(.FIFO_DEPTH(2), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .err_pulse(err_pulse), .err_cnt(err_cnt), .word_cnt(word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                       input logic [3:0] rt, input logic [15:0] imm);
    in_valid  = 1'b1;
    in_opcode = op;
    in_rd     = rd;
    in_rs     = rs;
    in_rt     = rt;
    in_imm    = imm;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_opcode = '0; in_rd = '0; in_rs = '0; in_rt = '0; in_imm = '0;
    step(); step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (err_cnt !== 8'd0 || err_pulse !== 1'b0) begin bad++; $display("[TB] FAIL reset_err got=%0d/%b want=0/0", err_cnt, err_pulse); end
    total++; if (word_cnt !== 16'd0 || out_instr !== 16'h0000) begin bad++; $display("[TB] FAIL reset_cnt got=%h/%h want=0/0", word_cnt, out_instr); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    drive(4'h8, 4'hA, 4'hA, 4'h0, 16'hFFFD);
    step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_instr !== 16'h8AAD) begin bad++; $display("[TB] FAIL basic_word got=%b/%h want=1/8aad", out_valid, out_instr); end
    step();
    exp_wc++;
    total++; if (out_valid !== 1'b0 || word_cnt !== exp_wc) begin bad++; $display("[TB] FAIL basic_pop got=%b/%0d want=0/%0d", out_valid, word_cnt, exp_wc); end
  endtask

  task automatic test_classes();
    logic [3:0]  op [5]  = '{4'hA, 4'hE, 4'h4, 4'h2, 4'hF};
    logic [3:0]  rd [5]  = '{4'hA, 4'h5, 4'hA, 4'h1, 4'h7};
    logic [3:0]  rs [5]  = '{4'h0, 4'h0, 4'hA, 4'h2, 4'h7};
    logic [3:0]  rt [5]  = '{4'h0, 4'h0, 4'h0, 4'h3, 4'h7};
    logic [15:0] imm [5] = '{16'hFFA4, 16'hFF24, 16'h000F, 16'hFFFF, 16'h1234};
    logic [15:0] exp [5] = '{16'hAAA4, 16'hEB24, 16'h4AAF, 16'h2123, 16'hF000};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(op[i], rd[i], rs[i], rt[i], imm[i]);
      step();
      total++; if (out_valid !== 1'b1 || out_instr !== exp[i] || err_pulse !== 1'b0) begin
        bad++; $display("[TB] FAIL class_%0d got=%b/%h/%b want=1/%h/0", i, out_valid, out_instr, err_pulse, exp[i]);
      end
    end
    in_valid = 1'b0;
    step();
    exp_wc += 16'd5;
    total++; if (word_cnt !== exp_wc || err_cnt !== 8'd0) begin bad++; $display("[TB] FAIL class_counts got=%0d/%0d want=%0d/0", word_cnt, err_cnt, exp_wc); end
  endtask

  task automatic test_range_error();
    out_ready = 1'b1;
    drive(4'h8, 4'hA, 4'hA, 4'h0, 16'h0008);
    step();
    total++; if (err_pulse !== 1'b1 || err_cnt !== 8'd1) begin bad++; $display("[TB] FAIL err1 got=%b/%0d want=1/1", err_pulse, err_cnt); end
`ifdef IMM_CLAMP_EN
    total++; if (out_valid !== 1'b1 || out_instr !== 16'h8AA7) begin bad++; $display("[TB] FAIL clamp1 got=%b/%h want=1/8aa7", out_valid, out_instr); end
`else
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL drop1 got=%b want=0", out_valid); end
`endif
    drive(4'hB, 4'h3, 4'h0, 4'h0, 16'h0100);
    step();
    in_valid = 1'b0;
    total++; if (err_pulse !== 1'b1 || err_cnt !== 8'd2) begin bad++; $display("[TB] FAIL err2 got=%b/%0d want=1/2", err_pulse, err_cnt); end
`ifdef IMM_CLAMP_EN
    total++; if (out_valid !== 1'b1 || out_instr !== 16'hB3FF) begin bad++; $display("[TB] FAIL clamp2 got=%b/%h want=1/b3ff", out_valid, out_instr); end
    exp_wc += 16'd2;
`else
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL drop2 got=%b want=0", out_valid); end
`endif
    step();
    total++; if (err_pulse !== 1'b0 || out_valid !== 1'b0 || word_cnt !== exp_wc) begin
      bad++; $display("[TB] FAIL err_after got=%b/%b/%0d want=0/0/%0d", err_pulse, out_valid, word_cnt, exp_wc);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  rd [3]  = '{4'h1, 4'h4, 4'h7};
    logic        rdy [3] = '{1'b1, 1'b1, 1'b0};
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(4'h0, rd[i], rd[i] + 4'h1, rd[i] + 4'h2, 16'h0000);
      total++; if (in_ready !== rdy[i]) begin bad++; $display("[TB] FAIL b2b_ready_%0d got=%b want=%b", i, in_ready, rdy[i]); end
      step();
    end
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_instr !== 16'h0123 || in_ready !== 1'b0) begin
      bad++; $display("[TB] FAIL b2b_full got=%b/%h/%b want=1/0123/0", out_valid, out_instr, in_ready);
    end
    out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b1 || out_instr !== 16'h0456 || in_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL b2b_second got=%b/%h/%b want=1/0456/1", out_valid, out_instr, in_ready);
    end
    step();
    exp_wc += 16'd2;
    total++; if (out_valid !== 1'b0 || word_cnt !== exp_wc) begin bad++; $display("[TB] FAIL b2b_drain got=%b/%0d want=0/%0d", out_valid, word_cnt, exp_wc); end
  endtask

  task automatic test_simultaneous();
    out_ready = 1'b0;
    drive(4'h7, 4'h1, 4'h1, 4'h1, 16'h0000);
    step();
    drive(4'h3, 4'hA, 4'hB, 4'hC, 16'h0000);
    out_ready = 1'b1;
    total++; if (out_instr !== 16'h7111) begin bad++; $display("[TB] FAIL sim_head got=%h want=7111", out_instr); end
    step();
    exp_wc++;
    in_valid = 1'b0;
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b1 || out_instr !== 16'h3ABC || in_ready !== 1'b1 || word_cnt !== exp_wc) begin
      bad++; $display("[TB] FAIL sim_swap got=%b/%h/%b/%0d want=1/3abc/1/%0d", out_valid, out_instr, in_ready, word_cnt, exp_wc);
    end
    step();
    out_ready = 1'b1;
    step();
    exp_wc++;
    total++; if (out_valid !== 1'b0 || word_cnt !== exp_wc) begin bad++; $display("[TB] FAIL sim_drain got=%b/%0d want=0/%0d", out_valid, word_cnt, exp_wc); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    drive(4'h1, 4'h2, 4'h3, 4'h4, 16'h0000);
    step(); step();
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0 || err_cnt !== 8'd2) begin bad++; $display("[TB] FAIL mid_full got=%b/%0d want=0/2", in_ready, err_cnt); end
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_cnt !== 8'd0 || word_cnt !== 16'd0) begin
      bad++; $display("[TB] FAIL mid_reset got=%b/%b/%0d/%0d want=0/1/0/0", out_valid, in_ready, err_cnt, word_cnt);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_classes();
    test_range_error();
    test_back_to_back();
    test_simultaneous();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
